// File: rtl/rvc_asap_fpga_in_cond_if.sv
// Board-pin bundle for the FPGA input conditioner: raw KEY/SW pins in,
// debounced levels and event pulses out toward CR_MEM.
// Optional macro RVC_ASAP_PRESS_CNT_EN adds the per-button press counters.
interface rvc_asap_fpga_in_cond_if;
   logic       Button0Raw;
   logic       Button1Raw;
   logic [9:0] SwitchRaw;
   logic       Button_0;
   logic       Button_1;
   logic [9:0] Switch;
   logic       Button0Press;
   logic       Button1Press;
   logic       SwitchChg;
`ifdef RVC_ASAP_PRESS_CNT_EN
   logic [7:0] Button0PressCnt;
   logic [7:0] Button1PressCnt;
`endif

   // Board side: drives the raw pins and consumes conditioned values
   modport master (
      output Button0Raw, Button1Raw, SwitchRaw,
      input  Button_0, Button_1, Switch, Button0Press, Button1Press, SwitchChg
`ifdef RVC_ASAP_PRESS_CNT_EN
      , input Button0PressCnt, Button1PressCnt
`endif
   );

   // Conditioner side: samples raw pins and produces conditioned values
   modport slave (
      input  Button0Raw, Button1Raw, SwitchRaw,
      output Button_0, Button_1, Switch, Button0Press, Button1Press, SwitchChg
`ifdef RVC_ASAP_PRESS_CNT_EN
      , output Button0PressCnt, Button1PressCnt
`endif
   );
endinterface

// File: rtl/rvc_asap_fpga_in_cond.sv
// Input conditioner between raw FPGA board pins and CR_MEM.
// Synchronizes KEY0/KEY1/SW[9:0], debounces each button with its own FSM,
// debounces the switch bus as a group and emits one-cycle event pulses.
// Optional macro RVC_ASAP_PRESS_CNT_EN adds 8-bit wrapping press counters.
module rvc_asap_fpga_in_cond #(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = 500000,
   parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
   input logic                    Clock,
   input logic                    Rst,
   rvc_asap_fpga_in_cond_if.slave pins
);

   localparam int unsigned NUM_BTN = 2;
   localparam int unsigned SW_W    = 10;
   localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   // The sample that opens a pending window is itself the first stable
   // cycle, so the window closes on the DEBOUNCE_CYCLES-th stable sample.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } btn_state_t;

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_sync;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;

   assign btn_raw = {pins.Button1Raw, pins.Button0Raw};

   // ---------------------------------------------------------------------
   // Per-button synchronizer and debounce FSM
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] chain;
      btn_state_t             state;
      logic [CNT_W-1:0]       cnt;
      logic                   level_q;
      logic                   press_q;

      // Synchronizer chain; resets to the released pin level
      always_ff @(posedge Clock or negedge Rst) begin
         if (!Rst) begin
            chain <= {SYNC_STAGES{BUTTON_ACTIVE_LOW}};
         end else begin
            chain <= {chain[SYNC_STAGES-2:0], btn_raw[gi]};
         end
      end

      // Polarity fixed at chain output so 1 always means pressed
      assign btn_sync[gi] = chain[SYNC_STAGES-1] ^ BUTTON_ACTIVE_LOW;

      // Debounce FSM with registered level and press pulse
      always_ff @(posedge Clock or negedge Rst) begin
         if (!Rst) begin
            state   <= STABLE_LO;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
         end else begin
            press_q <= 1'b0;
            case (state)
               STABLE_LO: begin
                  if (btn_sync[gi]) begin
                     state <= PEND_HI;
                     cnt   <= '0;
                  end
               end
               PEND_HI: begin
                  if (!btn_sync[gi]) begin
                     state <= STABLE_LO;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state   <= STABLE_HI;
                     cnt     <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               STABLE_HI: begin
                  if (!btn_sync[gi]) begin
                     state <= PEND_LO;
                     cnt   <= '0;
                  end
               end
               PEND_LO: begin
                  if (btn_sync[gi]) begin
                     state <= STABLE_HI;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state   <= STABLE_LO;
                     cnt     <= '0;
                     level_q <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state   <= STABLE_LO;
                  cnt     <= '0;
                  level_q <= 1'b0;
               end
            endcase
         end
      end

      assign btn_level[gi] = level_q;
      assign btn_press[gi] = press_q;
   end

   assign pins.Button_0     = btn_level[0];
   assign pins.Button_1     = btn_level[1];
   assign pins.Button0Press = btn_press[0];
   assign pins.Button1Press = btn_press[1];

   // ---------------------------------------------------------------------
   // Switch bus: synchronizer plus shared group debounce
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][SW_W-1:0] sw_chain;
   logic [SW_W-1:0]                  sw_sync;
   logic [SW_W-1:0]                  sw_cand;
   logic [SW_W-1:0]                  sw_q;
   logic [CNT_W-1:0]                 sw_cnt;
   logic                             sw_chg_q;

   // Switch synchronizer chain, one flop column per stage
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         sw_chain <= '0;
      end else begin
         sw_chain <= {sw_chain[SYNC_STAGES-2:0], pins.SwitchRaw};
      end
   end

   assign sw_sync = sw_chain[SYNC_STAGES-1];

   // Any bit moving restarts the window for the whole bus
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         sw_cand  <= '0;
         sw_q     <= '0;
         sw_cnt   <= '0;
         sw_chg_q <= 1'b0;
      end else begin
         sw_chg_q <= 1'b0;
         if (sw_sync != sw_cand) begin
            sw_cand <= sw_sync;
            sw_cnt  <= '0;
         end else if (sw_cand != sw_q) begin
            if (sw_cnt == CNT_LAST) begin
               sw_q     <= sw_cand;
               sw_chg_q <= 1'b1;
               sw_cnt   <= '0;
            end else begin
               sw_cnt <= sw_cnt + CNT_W'(1);
            end
         end else begin
            sw_cnt <= '0;
         end
      end
   end

   assign pins.Switch    = sw_q;
   assign pins.SwitchChg = sw_chg_q;

`ifdef RVC_ASAP_PRESS_CNT_EN
   // ---------------------------------------------------------------------
   // Press counters, wrap 255 -> 0
   // ---------------------------------------------------------------------
   logic [7:0] press_cnt0;
   logic [7:0] press_cnt1;

   // Count committed presses per button
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         press_cnt0 <= 8'd0;
         press_cnt1 <= 8'd0;
      end else begin
         if (btn_press[0]) press_cnt0 <= press_cnt0 + 8'd1;
         if (btn_press[1]) press_cnt1 <= press_cnt1 + 8'd1;
      end
   end

   assign pins.Button0PressCnt = press_cnt0;
   assign pins.Button1PressCnt = press_cnt1;
`endif

endmodule

// File: tb/tb_rvc_asap_fpga_in_cond.sv
// Directed self-checking bench for rvc_asap_fpga_in_cond with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BUTTON_ACTIVE_LOW=1 (6-edge latency).
// Optional macro RVC_ASAP_PRESS_CNT_EN enables the press-counter test.
module tb_rvc_asap_fpga_in_cond;
   logic Clock = 1'b0;
   logic Rst   = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   p0_seen = 0;
   int   p1_seen = 0;
   int   chg_seen = 0;

   rvc_asap_fpga_in_cond_if pif ();

   rvc_asap_fpga_in_cond #(
      .SYNC_STAGES      (2),
      .DEBOUNCE_CYCLES  (4),
      .BUTTON_ACTIVE_LOW(1'b1)
   ) dut (
      .Clock(Clock),
      .Rst  (Rst),
      .pins (pif.slave)
   );

   always #5 Clock = ~Clock;

   // Pulse tallies sampled away from the active edge
   always @(negedge Clock) begin
      if (pif.Button0Press === 1'b1) p0_seen = p0_seen + 1;
      if (pif.Button1Press === 1'b1) p1_seen = p1_seen + 1;
      if (pif.SwitchChg === 1'b1)    chg_seen = chg_seen + 1;
   end

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic step(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      pif.Button0Raw = 1'b0;
      pif.Button1Raw = 1'b1;
      pif.SwitchRaw  = 10'h000;
      Rst = 1'b0;
      step(4);
      checks++; if (pif.Button_0 !== 1'b0) begin errors++; $display("FAIL rst_btn0: got %b want 0", pif.Button_0); end
      checks++; if (pif.Button_1 !== 1'b0) begin errors++; $display("FAIL rst_btn1: got %b want 0", pif.Button_1); end
      checks++; if (pif.Switch !== 10'h000) begin errors++; $display("FAIL rst_switch: got %h want 000", pif.Switch); end
      checks++; if ({pif.Button0Press, pif.Button1Press, pif.SwitchChg} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {pif.Button0Press, pif.Button1Press, pif.SwitchChg}); end
      Rst = 1'b1;
      step(5);
      checks++; if (pif.Button_0 !== 1'b0) begin errors++; $display("FAIL rst_btn0_early: got %b want 0 after 5 edges", pif.Button_0); end
      step(1);
      checks++; if (pif.Button_0 !== 1'b1) begin errors++; $display("FAIL rst_btn0_rise: got %b want 1 after 6 edges", pif.Button_0); end
      checks++; if (pif.Button0Press !== 1'b1) begin errors++; $display("FAIL rst_press0_on: got %b want 1", pif.Button0Press); end
      step(1);
      checks++; if (pif.Button0Press !== 1'b0) begin errors++; $display("FAIL rst_press0_off: got %b want 0", pif.Button0Press); end
      checks++; if (p0_seen !== 1) begin errors++; $display("FAIL rst_press0_count: got %0d want 1", p0_seen); end
      pif.Button0Raw = 1'b1;
      step(6);
      checks++; if (pif.Button_0 !== 1'b0) begin errors++; $display("FAIL rst_btn0_release: got %b want 0", pif.Button_0); end
   endtask

   task automatic test_clean_press();
      int p1_before;
      p1_before = p1_seen;
      pif.Button1Raw = 1'b0;
      step(5);
      checks++; if (pif.Button_1 !== 1'b0) begin errors++; $display("FAIL press_btn1_early: got %b want 0", pif.Button_1); end
      step(1);
      checks++; if (pif.Button_1 !== 1'b1) begin errors++; $display("FAIL press_btn1_rise: got %b want 1", pif.Button_1); end
      checks++; if (pif.Button1Press !== 1'b1) begin errors++; $display("FAIL press_pulse1_on: got %b want 1", pif.Button1Press); end
      step(1);
      checks++; if (pif.Button1Press !== 1'b0) begin errors++; $display("FAIL press_pulse1_off: got %b want 0", pif.Button1Press); end
      pif.Button1Raw = 1'b1;
      step(5);
      checks++; if (pif.Button_1 !== 1'b1) begin errors++; $display("FAIL release_btn1_early: got %b want 1", pif.Button_1); end
      step(1);
      checks++; if (pif.Button_1 !== 1'b0) begin errors++; $display("FAIL release_btn1_fall: got %b want 0", pif.Button_1); end
      step(3);
      checks++; if (p1_seen - p1_before !== 1) begin errors++; $display("FAIL press_release_pulses: got %0d want 1", p1_seen - p1_before); end
   endtask

   task automatic test_glitch();
      int p0_before;
      p0_before = p0_seen;
      pif.Button0Raw = 1'b0;
      step(3);
      pif.Button0Raw = 1'b1;
      step(10);
      checks++; if (pif.Button_0 !== 1'b0) begin errors++; $display("FAIL glitch_btn0: got %b want 0", pif.Button_0); end
      checks++; if (p0_seen - p0_before !== 0) begin errors++; $display("FAIL glitch_press0: got %0d pulses want 0", p0_seen - p0_before); end
   endtask

   task automatic test_switch_bounce();
      int c_before;
      c_before = chg_seen;
      pif.SwitchRaw = 10'h005;
      step(1);
      pif.SwitchRaw = 10'h001;
      step(1);
      pif.SwitchRaw = 10'h005;
      step(5);
      checks++; if (pif.Switch !== 10'h000) begin errors++; $display("FAIL sw_early: got %h want 000", pif.Switch); end
      step(1);
      checks++; if (pif.Switch !== 10'h005) begin errors++; $display("FAIL sw_commit: got %h want 005", pif.Switch); end
      checks++; if (pif.SwitchChg !== 1'b1) begin errors++; $display("FAIL sw_chg_on: got %b want 1", pif.SwitchChg); end
      step(1);
      checks++; if (pif.SwitchChg !== 1'b0) begin errors++; $display("FAIL sw_chg_off: got %b want 0", pif.SwitchChg); end
      step(5);
      checks++; if (chg_seen - c_before !== 1) begin errors++; $display("FAIL sw_chg_count: got %0d want 1", chg_seen - c_before); end
      // Short excursion that reverts before commit
      c_before = chg_seen;
      pif.SwitchRaw = 10'h00F;
      step(2);
      pif.SwitchRaw = 10'h005;
      step(10);
      checks++; if (pif.Switch !== 10'h005) begin errors++; $display("FAIL sw_revert_value: got %h want 005", pif.Switch); end
      checks++; if (chg_seen - c_before !== 0) begin errors++; $display("FAIL sw_revert_pulse: got %0d want 0", chg_seen - c_before); end
   endtask

   task automatic test_simultaneous();
      pif.Button0Raw = 1'b0;
      pif.Button1Raw = 1'b0;
      step(6);
      checks++; if ({pif.Button_0, pif.Button_1} !== 2'b11) begin errors++; $display("FAIL sim_levels: got %b want 11", {pif.Button_0, pif.Button_1}); end
      checks++; if ({pif.Button0Press, pif.Button1Press} !== 2'b11) begin errors++; $display("FAIL sim_pulses: got %b want 11", {pif.Button0Press, pif.Button1Press}); end
      step(1);
      checks++; if ({pif.Button0Press, pif.Button1Press} !== 2'b00) begin errors++; $display("FAIL sim_pulses_off: got %b want 00", {pif.Button0Press, pif.Button1Press}); end
      pif.Button0Raw = 1'b1;
      pif.Button1Raw = 1'b1;
      step(7);
      checks++; if ({pif.Button_0, pif.Button_1} !== 2'b00) begin errors++; $display("FAIL sim_release: got %b want 00", {pif.Button_0, pif.Button_1}); end
   endtask

   task automatic test_mid_reset();
      int p0_before;
      int p1_before;
      pif.Button1Raw = 1'b0;
      step(7);
      checks++; if (pif.Button_1 !== 1'b1) begin errors++; $display("FAIL mid_pre_btn1: got %b want 1", pif.Button_1); end
      pif.Button0Raw = 1'b0;
      step(5);
      Rst = 1'b0;
      #1;
      checks++; if ({pif.Button_0, pif.Button_1} !== 2'b00) begin errors++; $display("FAIL mid_rst_levels: got %b want 00", {pif.Button_0, pif.Button_1}); end
      checks++; if (pif.Switch !== 10'h000) begin errors++; $display("FAIL mid_rst_switch: got %h want 000", pif.Switch); end
      pif.Button0Raw = 1'b1;
      pif.Button1Raw = 1'b1;
      step(2);
      p0_before = p0_seen;
      p1_before = p1_seen;
      Rst = 1'b1;
      step(20);
      checks++; if ((p0_seen - p0_before) + (p1_seen - p1_before) !== 0) begin errors++; $display("FAIL mid_rst_no_press: got %0d pulses want 0", (p0_seen - p0_before) + (p1_seen - p1_before)); end
      checks++; if ({pif.Button_0, pif.Button_1} !== 2'b00) begin errors++; $display("FAIL mid_rst_after: got %b want 00", {pif.Button_0, pif.Button_1}); end
   endtask

`ifdef RVC_ASAP_PRESS_CNT_EN
   task automatic test_press_cnt();
      checks++; if ({pif.Button0PressCnt, pif.Button1PressCnt} !== 16'h0000) begin errors++; $display("FAIL cnt_start: got %h want 0000", {pif.Button0PressCnt, pif.Button1PressCnt}); end
      for (int i = 0; i < 256; i++) begin
         pif.Button0Raw = 1'b0;
         pif.Button1Raw = 1'b0;
         step(7);
         pif.Button0Raw = 1'b1;
         pif.Button1Raw = 1'b1;
         step(7);
         if (i == 254) begin
            checks++; if ({pif.Button0PressCnt, pif.Button1PressCnt} !== 16'hFFFF) begin errors++; $display("FAIL cnt_255: got %h want ffff", {pif.Button0PressCnt, pif.Button1PressCnt}); end
         end
      end
      checks++; if ({pif.Button0PressCnt, pif.Button1PressCnt} !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h want 0000", {pif.Button0PressCnt, pif.Button1PressCnt}); end
   endtask
`endif

   initial begin
      pif.Button0Raw = 1'b1;
      pif.Button1Raw = 1'b1;
      pif.SwitchRaw  = 10'h000;
      test_reset();
      test_clean_press();
      test_glitch();
      test_switch_bounce();
      test_simultaneous();
      test_mid_reset();
`ifdef RVC_ASAP_PRESS_CNT_EN
      test_press_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
